// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one bit per clock).
// Latency: BW+1 cycles from accepted start to done for a valid operand, 1 cycle for an invalid one.
// Backpressure: none; start is sampled only in IDLE, requests during CONV/DONE are dropped.
module bcd_to_bin_seq #(
   parameter int NDIG = 2,
   parameter int BW   = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [4*NDIG-1:0] bcd_in,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [BW-1:0]     bin_out
);

   localparam int CW = (BW > 1) ? $clog2(BW) : 1;
   localparam logic [CW-1:0] LAST = CW'(BW - 1);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [4*NDIG-1:0] bcd_sr;
   logic [4*NDIG-1:0] bcd_shf;
   logic [4*NDIG-1:0] bcd_nxt;
   logic [BW-1:0]     bin_sr;
   logic [BW-1:0]     bin_nxt;
   logic              bad;

   // One reverse double-dabble step: shift right, then pull every nibble >= 8 back by 3.
   always_comb begin
      bcd_shf = bcd_sr >> 1;
      bin_nxt = {bcd_sr[0], bin_sr[BW-1:1]};
      bcd_nxt = bcd_shf;
      for (int i = 0; i < NDIG; i++) begin
         if (bcd_shf[4*i +: 4] >= 4'd8)
            bcd_nxt[4*i +: 4] = bcd_shf[4*i +: 4] - 4'd3;
      end
   end

   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (bcd_in[4*i +: 4] > 4'd9)
            bad = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bcd_sr  <= '0;
         bin_sr  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         bin_out <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (bad) begin
                     state   <= DONE;
                     done    <= 1'b1;
                     err     <= 1'b1;
                     bin_out <= '0;
                  end else begin
                     state  <= CONV;
                     busy   <= 1'b1;
                     bcd_sr <= bcd_in;
                     bin_sr <= '0;
                     cnt    <= '0;
                  end
               end
            end
            CONV: begin
               bcd_sr <= bcd_nxt;
               bin_sr <= bin_nxt;
               cnt    <= cnt + CW'(1);
               if (cnt == LAST) begin
                  state   <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  err     <= 1'b0;
                  bin_out <= bin_nxt;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: reset, edge values, invalid digits, ignored starts,
// mid-conversion reset and an exhaustive 0..99 sweep with random idle gaps.
module tb_bcd_to_bin_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] bcd_in;
   logic       busy;
   logic       done;
   logic       err;
   logic [6:0] bin_out;

   int errors = 0;
   int checks = 0;

   bcd_to_bin_seq #(.NDIG(2), .BW(7)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bcd_in  (bcd_in),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .bin_out (bin_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Issue one start at a negedge and follow the conversion until done.
   task automatic run(input string tag, input logic [7:0] b, input int exp_bin,
                      input logic exp_err, input int exp_lat, input int exp_busy);
      int         n;
      int         nbusy;
      logic       seen;
      logic       stable;
      logic [6:0] prev;
      prev   = bin_out;
      stable = 1'b1;
      seen   = 1'b0;
      nbusy  = 0;
      bcd_in = b;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      bcd_in = ~b;
      for (n = 1; n <= 20; n++) begin
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (busy === 1'b1) nbusy++;
         if (bin_out !== prev) stable = 1'b0;
         @(negedge clk);
      end
      check({tag, "_seen"}, 32'(seen), 32'd1);
      check({tag, "_lat"}, n, exp_lat);
      check({tag, "_bin"}, 32'(bin_out), exp_bin);
      check({tag, "_err"}, 32'(err), 32'(exp_err));
      check({tag, "_busy"}, nbusy, exp_busy);
      check({tag, "_stable"}, 32'(stable), 32'd1);
      @(negedge clk);
      check({tag, "_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      int  n;
      int  ndone;
      rst    = 1'b1;
      start  = 1'b0;
      bcd_in = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      check("rst_bin", 32'(bin_out), 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);
      check("idle_done", 32'(done), 0);
      check("idle_bin", 32'(bin_out), 0);

      run("h81", 8'h81, 81, 1'b0, 8, 7);
      run("h00", 8'h00, 0, 1'b0, 8, 7);
      run("h99", 8'h99, 99, 1'b0, 8, 7);
      run("h09", 8'h09, 9, 1'b0, 8, 7);
      run("h10", 8'h10, 10, 1'b0, 8, 7);
      run("h3A", 8'h3A, 0, 1'b1, 1, 0);
      run("hA5", 8'hA5, 0, 1'b1, 1, 0);

      // start held high through CONV: only one done, next accept after DONE
      bcd_in = 8'h42;
      start  = 1'b1;
      @(negedge clk);
      bcd_in = 8'h17;
      ndone  = 0;
      for (n = 1; n <= 20; n++) begin
         if (done === 1'b1) break;
         @(negedge clk);
      end
      check("hold_lat1", n, 8);
      check("hold_bin1", 32'(bin_out), 42);
      check("hold_err1", 32'(err), 0);
      for (n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (done === 1'b1) break;
      end
      start = 1'b0;
      check("hold_lat2", n, 9);
      check("hold_bin2", 32'(bin_out), 17);
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      check("hold_nodone", ndone, 0);

      // reset in the middle of a conversion
      bcd_in = 8'h55;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_busy_pre", 32'(busy), 1);
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 0);
      check("abort_done", 32'(done), 0);
      check("abort_bin", 32'(bin_out), 0);
      check("abort_err", 32'(err), 0);
      ndone = 0;
      repeat (2) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      check("abort_nodone", ndone, 0);
      run("h07", 8'h07, 7, 1'b0, 8, 7);

      for (int v = 0; v < 100; v++) begin
         logic [7:0] b;
         b = {4'(v / 10), 4'(v % 10)};
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run("sweep", b, v, 1'b0, 8, 7);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
